// File: rtl/rom_arb_pkg.sv
// Shared defaults and FSM state type for the instruction-ROM port arbiter.
// Imported by the arbiter top and by the starvation counter.
package rom_arb_pkg;

  localparam int ROM_ADDR_W = 10;
  localparam int ROM_DATA_W = 32;
  localparam int WAIT_W     = 4;

  typedef enum logic {
    PRIO_IF   = 1'b0,
    FORCE_DBG = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rom_arb_age_counter.sv
// Saturating starvation counter for the debug port.
// The full flag is raised once the count sits at MAX_WAIT.
module rom_arb_age_counter
  import rom_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] cnt,
  output logic              full
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q;

  // clear has priority over increment; the count never wraps past MAX_CNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != MAX_CNT)) begin
      cnt_q <= cnt_q + WAIT_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == MAX_CNT);

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter (fetch, debug) in front of an asynchronous instruction ROM.
// Fetch wins ties unless debug has been starved for MAX_WAIT cycles.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = ROM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic              if_gnt_c, dbg_gnt_c;
  logic [WAIT_W-1:0] age_cnt;
  logic              age_full;
  logic              age_reach;
  logic              dbg_starved;

  logic              if_vld_p1, dbg_vld_p1;
  logic [DATA_W-1:0] if_data_p1, dbg_data_p1;

  // p0: combinational grant from request and current state
  assign dbg_starved = dbg_req & ~dbg_gnt_c;
  // the count reaches MAX_WAIT at this edge, so switch state at the same edge
  assign age_reach   = age_full | (age_cnt == LAST_WAIT);

  always_comb begin
    state_d   = state_q;
    if_gnt_c  = 1'b0;
    dbg_gnt_c = 1'b0;
    case (state_q)
      PRIO_IF: begin
        if (if_req) begin
          if_gnt_c = 1'b1;
        end else if (dbg_req) begin
          dbg_gnt_c = 1'b1;
        end
        if (dbg_req && !dbg_gnt_c && age_reach) begin
          state_d = FORCE_DBG;
        end
      end
      FORCE_DBG: begin
        dbg_gnt_c = dbg_req;
        state_d   = PRIO_IF;
      end
      default: state_d = PRIO_IF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRIO_IF;
    end else begin
      state_q <= state_d;
    end
  end

  rom_arb_age_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dbg_starved),
    .clr   (~dbg_starved),
    .cnt   (age_cnt),
    .full  (age_full)
  );

  // grants are suppressed while reset is held so no read can be launched
  assign if_gnt   = if_gnt_c & rst_n;
  assign dbg_gnt  = dbg_gnt_c & rst_n;
  assign rom_addr = dbg_gnt_c ? dbg_addr : if_addr;

  // p1: capture ROM data for the granted port; the other port's data holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_vld_p1   <= 1'b0;
      dbg_vld_p1  <= 1'b0;
      if_data_p1  <= '0;
      dbg_data_p1 <= '0;
    end else begin
      if_vld_p1  <= if_gnt;
      dbg_vld_p1 <= dbg_gnt;
      if (if_gnt) begin
        if_data_p1 <= rom_data;
      end
      if (dbg_gnt) begin
        dbg_data_p1 <= rom_data;
      end
    end
  end

  assign if_rvalid  = if_vld_p1;
  assign if_rdata   = if_data_p1;
  assign dbg_rvalid = dbg_vld_p1;
  assign dbg_rdata  = dbg_data_p1;

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: ROM word-address width (1024 words).
REQ-002 Parameter DATA_W, default 32: ROM word width.
REQ-003 Parameter MAX_WAIT, default 4, range 1..15: consecutive denied cycles after which debug is forced.
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch read request.
REQ-007 if_addr  in  ADDR_W  fetch word address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  if_rdata valid, one-cycle pulse.
REQ-010 if_rdata  out  DATA_W  fetch read data.
REQ-011 dbg_req  in  1  debug/loader read request.
REQ-012 dbg_addr  in  ADDR_W  debug word address.
REQ-013 dbg_gnt  out  1  debug request accepted this cycle.
REQ-014 dbg_rvalid  out  1  dbg_rdata valid, one-cycle pulse.
REQ-015 dbg_rdata  out  DATA_W  debug read data.
REQ-016 rom_addr  out  ADDR_W  address to the asynchronous instruction ROM.
REQ-017 rom_data  in  DATA_W  combinational ROM output for rom_addr.

Function
REQ-018 At most one of if_gnt/dbg_gnt SHALL be high in any cycle; grants are combinational from req and current state.
REQ-019 rom_addr SHALL equal the granted requester's address, else if_addr.
REQ-020 On a grant, rom_data SHALL be registered at that CLK edge; the granted port's rvalid SHALL be high exactly the following cycle with that data (latency 1).
REQ-021 rdata outputs SHALL hold their last value when rvalid is low; the other port's rdata SHALL NOT change.
REQ-022 FSM states: PRIO_IF (fetch wins ties) and FORCE_DBG (debug wins ties).
REQ-023 PRIO_IF: if_req -> grant fetch; else dbg_req -> grant debug; else no grant.
REQ-024 wait_cnt (4 bits) SHALL increment each cycle dbg_req is high and not granted, and clear when dbg_req is low or debug is granted.
REQ-025 PRIO_IF -> FORCE_DBG when wait_cnt reaches MAX_WAIT with dbg_req still high at that edge.
REQ-026 FORCE_DBG: dbg_req -> grant debug, then return to PRIO_IF; dbg_req low -> return to PRIO_IF without a grant.
REQ-027 Requesters SHALL hold req and addr stable until granted; the block SHALL NOT latch an ungranted request.
REQ-028 Back-to-back grants to the same port SHALL be allowed every cycle (full throughput, no bubbles).
REQ-029 wait_cnt SHALL saturate at MAX_WAIT and never wrap.

Reset
REQ-030 RESET_N low SHALL immediately force state PRIO_IF, wait_cnt 0, if_rvalid 0, dbg_rvalid 0, if_rdata 0, dbg_rdata 0.
REQ-031 While RESET_N is low, if_gnt and dbg_gnt SHALL be 0.
REQ-032 Reset between a grant and its rvalid SHALL discard that read; no rvalid SHALL appear after reset release.

Structure
REQ-033 Package rom_arb_pkg SHALL hold ADDR_W/DATA_W defaults and the state enum typedef (PRIO_IF, FORCE_DBG).
REQ-034 Starvation counter SHALL be a sub-module rom_arb_age_counter (inc, clr, saturate at MAX_WAIT, flag at MAX_WAIT).
REQ-035 The ROM SHALL remain outside this block, connected only via rom_addr/rom_data.

Verification
REQ-036 if_req only, addresses 0,1,2 consecutive -> if_gnt 3 cycles, if_rvalid cycles 2..4 with mem[0..2], dbg outputs idle.
REQ-037 dbg_req only, addr 0x3FF -> dbg_gnt same cycle, dbg_rvalid next cycle with mem[0x3FF].
REQ-038 if_req and dbg_req held continuously, MAX_WAIT=4 -> fetch granted 4 cycles, debug granted cycle 5, pattern repeats 4:1.
REQ-039 dbg_req dropped after 3 denied cycles -> wait_cnt clears to 0, no FORCE_DBG entry, no dbg_gnt.
REQ-040 RESET_N pulsed low the cycle after an if_gnt -> if_rvalid stays 0, all outputs at reset values, state PRIO_IF.
REQ-041 Random req/addr with assertions: never both gnt, rvalid exactly one cycle after gnt, data matches ROM model, debug wait never exceeds MAX_WAIT+1 cycles.
